prng_stream_checker: RTL and testbench

- Receive-side companion to the team's 8-bit PRNG generator. Consumes the generator's byte stream and runs its own reference copy of the same 16-bit LFSR from a known 8-bit seed.
- Aligns to the head of the stream and reports lock status, per-byte match pulses, a saturating error count and sticky loss-of-sync.
- Used on the bench and on silicon bring-up boards, looped back from the generator's outputs.

---
 rtl/prng_pkg.sv | 27 ++
 rtl/prng_stream_checker_if.sv | 12 +
 rtl/prng_ref_model.sv | 42 ++++
 rtl/prng_stream_checker.sv | 141 ++++++++++++++
 tb/tb_prng_stream_checker.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/prng_pkg.sv
// Shared PRNG definitions: 16-bit LFSR step, byte extraction and checker states.
// Reused by the generator and the stream checker so both sides agree bit-for-bit.
package prng_pkg;

    localparam int unsigned STATE_W = 16;
    localparam int unsigned BYTE_W  = 8;

    // Feedback taps at bits 15, 14, 12 and 3
    localparam logic [STATE_W-1:0] LFSR_TAPS = 16'hD008;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2,
        ST_LOST   = 2'd3
    } chk_state_t;

    function automatic logic [STATE_W-1:0] lfsr_step(input logic [STATE_W-1:0] s);
        return {s[STATE_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    // rotl1(high byte) XOR rotr1(low byte)
    function automatic logic [BYTE_W-1:0] lfsr_out(input logic [STATE_W-1:0] s);
        return {s[14:8], s[15]} ^ {s[0], s[7:1]};
    endfunction

endpackage

// File: rtl/prng_stream_checker_if.sv
// Byte-stream handshake between the PRNG generator (master) and the checker (slave).
interface prng_stream_checker_if;
    import prng_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/prng_ref_model.sv
// Reference LFSR for the checker: holds the latched seed and running state S,
// exposing E(S) and E({seed,seed}) combinationally.
module prng_ref_model
    import prng_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [BYTE_W-1:0] i_seed,
    input  logic              i_step,
    input  logic              i_rewind,
    input  logic              i_reanchor,
    output logic [BYTE_W-1:0] o_expect,
    output logic [BYTE_W-1:0] o_expect_seed
);

    logic [BYTE_W-1:0]  r_seed;
    logic [STATE_W-1:0] r_lfsr;
    logic [STATE_W-1:0] w_seed_state;

    assign w_seed_state  = {r_seed, r_seed};
    assign o_expect      = lfsr_out(r_lfsr);
    assign o_expect_seed = lfsr_out(w_seed_state);

    // Re-anchor lands one step past the seed state: the anchoring byte is already consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seed <= '0;
            r_lfsr <= '0;
        end else if (i_start) begin
            r_seed <= i_seed;
            r_lfsr <= {i_seed, i_seed};
        end else if (i_reanchor) begin
            r_lfsr <= lfsr_step(w_seed_state);
        end else if (i_rewind) begin
            r_lfsr <= w_seed_state;
        end else if (i_step) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

endmodule

// File: rtl/prng_stream_checker.sv
// Receive-side PRNG stream checker: aligns to the generator stream, tracks lock,
// pulses per-byte match/mismatch, counts errors while locked and flags sticky loss.
module prng_stream_checker
    import prng_pkg::*;
#(
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned ERR_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BYTE_W-1:0]    seed,
    input  logic                 start,
    prng_stream_checker_if.slave stream,
    output logic                 match,
    output logic                 mismatch,
    output logic                 locked,
    output logic                 lost,
    output logic [ERR_W-1:0]     err_count
);

    chk_state_t        r_fsm;
    chk_state_t        w_fsm_next;
    logic [3:0]        r_run;
    logic [7:0]        r_miss;
    logic [ERR_W-1:0]  r_err;
    logic              r_match;
    logic              r_mismatch;

    logic [BYTE_W-1:0] w_expect;
    logic [BYTE_W-1:0] w_expect_seed;
    logic              w_in_search;
    logic              w_in_locked;
    logic              w_accept;
    logic              w_hit;
    logic              w_anchor_hit;
    logic              w_step;
    logic              w_rewind;
    logic              w_reanchor;
    logic [3:0]        w_run_inc;
    logic [7:0]        w_miss_inc;
    logic              w_run_done;
    logic              w_loss;

    assign w_in_search  = (r_fsm == ST_SEARCH);
    assign w_in_locked  = (r_fsm == ST_LOCKED);
    // A handshake in the same cycle as start is dropped; start wins
    assign w_accept     = stream.in_valid & (w_in_search | w_in_locked) & ~start;
    assign w_hit        = (stream.in_data == w_expect);
    assign w_anchor_hit = (stream.in_data == w_expect_seed);
    assign w_run_inc    = r_run + 4'd1;
    assign w_miss_inc   = r_miss + 8'd1;
    assign w_run_done   = (w_run_inc == 4'(LOCK_COUNT));
    assign w_loss       = (w_miss_inc == 8'(LOSS_THRESH));

    assign w_step     = w_accept & ((w_in_search & w_hit) | w_in_locked);
    assign w_reanchor = w_accept & w_in_search & ~w_hit & w_anchor_hit;
    assign w_rewind   = w_accept & w_in_search & ~w_hit & ~w_anchor_hit;

    prng_ref_model u_ref (
        .clk           (clk),
        .rst           (rst),
        .i_start       (start),
        .i_seed        (seed),
        .i_step        (w_step),
        .i_rewind      (w_rewind),
        .i_reanchor    (w_reanchor),
        .o_expect      (w_expect),
        .o_expect_seed (w_expect_seed)
    );

    always_ff @(posedge clk) begin
        if (rst) r_fsm <= ST_IDLE;
        else     r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        if (start) begin
            w_fsm_next = ST_SEARCH;
        end else if (w_accept) begin
            case (r_fsm)
                ST_SEARCH: begin
                    if (w_hit) begin
                        if (w_run_done) w_fsm_next = ST_LOCKED;
                    end else if (w_anchor_hit && LOCK_COUNT == 1) begin
                        w_fsm_next = ST_LOCKED;
                    end
                end
                ST_LOCKED: if (!w_hit && w_loss) w_fsm_next = ST_LOST;
                default: ;
            endcase
        end
    end

    always_comb begin
        stream.in_ready = 1'b0;
        locked          = 1'b0;
        lost            = 1'b0;
        case (r_fsm)
            ST_SEARCH: stream.in_ready = 1'b1;
            ST_LOCKED: begin
                stream.in_ready = 1'b1;
                locked          = 1'b1;
            end
            ST_LOST:   lost = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_run      <= '0;
            r_miss     <= '0;
            r_err      <= '0;
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_match    <= w_accept & (w_hit | (w_in_search & w_anchor_hit));
            r_mismatch <= w_accept & w_in_locked & ~w_hit;
            if (w_accept && w_in_search) begin
                if (w_hit)             r_run <= w_run_done ? '0 : w_run_inc;
                else if (w_anchor_hit) r_run <= (LOCK_COUNT == 1) ? 4'd0 : 4'd1;
                else                   r_run <= '0;
            end
            if (w_accept && w_in_locked) begin
                if (w_hit) begin
                    r_miss <= '0;
                end else begin
                    r_miss <= w_miss_inc;
                    if (r_err != '1) r_err <= r_err + 1'b1;
                end
            end
        end
    end

    assign match     = r_match;
    assign mismatch  = r_mismatch;
    assign err_count = r_err;

endmodule

// File: tb/tb_prng_stream_checker.sv
// Directed bench for prng_stream_checker; expected bytes are the seed=0x01 stream
// E(S0..S12) = 82 05 0A 14 A8 D1 A3 C7 0F 9E 3D FA 77, derived by hand.
module tb_prng_stream_checker;

    logic       clk;
    logic       rst;
    logic [7:0] seed;
    logic       start;
    logic       start_b;
    logic       match, mismatch, locked, lost;
    logic [15:0] err_count;
    logic       match_b, mismatch_b, locked_b, lost_b;
    logic [3:0] err_b;

    int n_cmp;
    int n_err;

    prng_stream_checker_if ifa ();
    prng_stream_checker_if ifb ();

    prng_stream_checker #(.LOCK_COUNT(4), .LOSS_THRESH(8), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .seed(seed), .start(start), .stream(ifa),
        .match(match), .mismatch(mismatch), .locked(locked), .lost(lost),
        .err_count(err_count)
    );

    prng_stream_checker #(.LOCK_COUNT(4), .LOSS_THRESH(255), .ERR_W(4)) dut_sat (
        .clk(clk), .rst(rst), .seed(seed), .start(start_b), .stream(ifb),
        .match(match_b), .mismatch(mismatch_b), .locked(locked_b), .lost(lost_b),
        .err_count(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive on the falling edge, outputs sampled 1ns after the rising edge
    task automatic cyc(input logic st, input logic v, input logic [7:0] d);
        @(negedge clk);
        start        = st;
        ifa.in_valid = v;
        ifa.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic cycb(input logic st, input logic v, input logic [7:0] d);
        @(negedge clk);
        start_b      = st;
        ifb.in_valid = v;
        ifb.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; seed = 8'h00; start = 1'b0; start_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = 8'h00;
        ifb.in_valid = 1'b0; ifb.in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked",   locked,        1'b0);
        chk("rst_lost",     lost,          1'b0);
        chk("rst_match",    match,         1'b0);
        chk("rst_mismatch", mismatch,      1'b0);
        chk("rst_err",      err_count,     16'h0);
        chk("rst_ready",    ifa.in_ready,  1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Straight lock, seed 0x01
        seed = 8'h01;
        cyc(1'b1, 1'b0, 8'h00);
        chk("t1_ready", ifa.in_ready, 1'b1);
        cyc(1'b0, 1'b1, 8'h82); chk("t1_m0", match, 1'b1);
        cyc(1'b0, 1'b1, 8'h05); chk("t1_m1", match, 1'b1);
        cyc(1'b0, 1'b1, 8'h0A); chk("t1_m2", match, 1'b1); chk("t1_nolock", locked, 1'b0);
        cyc(1'b0, 1'b1, 8'h14); chk("t1_m3", match, 1'b1); chk("t1_lock", locked, 1'b1);
        chk("t1_err", err_count, 16'h0);
        cyc(1'b0, 1'b0, 8'h00); chk("t1_pulse", match, 1'b0);

        // Garbage before the head of the stream
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h33); chk("t2_g0", match, 1'b0); chk("t2_mm0", mismatch, 1'b0);
        cyc(1'b0, 1'b1, 8'h77); chk("t2_g1", match, 1'b0); chk("t2_mm1", mismatch, 1'b0);
        cyc(1'b0, 1'b1, 8'h82); chk("t2_m0", match, 1'b1);
        cyc(1'b0, 1'b1, 8'h05); chk("t2_m1", match, 1'b1);
        cyc(1'b0, 1'b1, 8'h0A); chk("t2_m2", match, 1'b1);
        cyc(1'b0, 1'b1, 8'h14); chk("t2_lock", locked, 1'b1); chk("t2_mm", mismatch, 1'b0);

        // Bad byte resets the run
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h82);
        cyc(1'b0, 1'b1, 8'h05);
        cyc(1'b0, 1'b1, 8'hFF); chk("t3_bad", match, 1'b0);
        cyc(1'b0, 1'b1, 8'h82); chk("t3_m0", match, 1'b1);
        cyc(1'b0, 1'b1, 8'h05);
        cyc(1'b0, 1'b1, 8'h0A); chk("t3_nolock", locked, 1'b0);
        cyc(1'b0, 1'b1, 8'h14); chk("t3_lock", locked, 1'b1);

        // Head-of-stream byte mid-run re-anchors onto S1
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h82);
        cyc(1'b0, 1'b1, 8'h05);
        cyc(1'b0, 1'b1, 8'h82); chk("ra_hit", match, 1'b1);
        cyc(1'b0, 1'b1, 8'h05); chk("ra_m1", match, 1'b1);
        cyc(1'b0, 1'b1, 8'h0A); chk("ra_m2", match, 1'b1); chk("ra_nolock", locked, 1'b0);
        cyc(1'b0, 1'b1, 8'h14); chk("ra_lock", locked, 1'b1);

        // Eight mismatches while locked -> LOST
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("t4_mm", mismatch, 1'b1);
            if (i == 6) chk("t4_still", locked, 1'b1);
        end
        chk("t4_err",    err_count,    16'd8);
        chk("t4_lost",   lost,         1'b1);
        chk("t4_locked", locked,       1'b0);
        chk("t4_ready",  ifa.in_ready, 1'b0);
        cyc(1'b0, 1'b1, 8'hA8);
        chk("t4_ign_mm", mismatch,  1'b0);
        chk("t4_ign_m",  match,     1'b0);
        chk("t4_ign_e",  err_count, 16'd8);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t4_rs_err",   err_count,    16'd0);
        chk("t4_rs_lost",  lost,         1'b0);
        chk("t4_rs_ready", ifa.in_ready, 1'b1);

        // Miss counter clears on a good byte while locked
        cyc(1'b0, 1'b1, 8'h82);
        cyc(1'b0, 1'b1, 8'h05);
        cyc(1'b0, 1'b1, 8'h0A);
        cyc(1'b0, 1'b1, 8'h14);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'hC7);
        chk("t5_good_m",  match,    1'b1);
        chk("t5_good_mm", mismatch, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("t5_err6", err_count, 16'd6);
        chk("t5_lock", locked,    1'b1);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        chk("t5_err8",  err_count, 16'd8);
        chk("t5_lock2", locked,    1'b1);
        chk("t5_lost",  lost,      1'b0);

        // Handshake coinciding with start is discarded
        cyc(1'b1, 1'b1, 8'h00);
        chk("st_mm",    mismatch,  1'b0);
        chk("st_err",   err_count, 16'd0);
        chk("st_lock",  locked,    1'b0);
        cyc(1'b0, 1'b1, 8'h82);
        chk("st_m0", match, 1'b1);

        // Seed 0x00: all-zero stream, then reset mid-stream with a byte in flight
        seed = 8'h00;
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("z_m", match, 1'b1);
        end
        chk("z_lock", locked, 1'b1);
        @(negedge clk);
        rst = 1'b1; ifa.in_valid = 1'b1; ifa.in_data = 8'h00;
        @(posedge clk);
        #1;
        chk("zr_lock",  locked,       1'b0);
        chk("zr_match", match,        1'b0);
        chk("zr_mm",    mismatch,     1'b0);
        chk("zr_lost",  lost,         1'b0);
        chk("zr_err",   err_count,    16'd0);
        chk("zr_ready", ifa.in_ready, 1'b0);

        // rst outranks start
        seed = 8'h01;
        cyc(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        chk("rp_ready", ifa.in_ready, 1'b0);

        // Saturation: ERR_W=4, LOSS_THRESH=255
        cycb(1'b1, 1'b0, 8'h00);
        cycb(1'b0, 1'b1, 8'h82);
        cycb(1'b0, 1'b1, 8'h05);
        cycb(1'b0, 1'b1, 8'h0A);
        cycb(1'b0, 1'b1, 8'h14);
        chk("sat_lock0", locked_b, 1'b1);
        for (int i = 0; i < 20; i++) cycb(1'b0, 1'b1, 8'h00);
        chk("sat_err",  err_b,    4'hF);
        chk("sat_lock", locked_b, 1'b1);
        chk("sat_lost", lost_b,   1'b0);
        cycb(1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
